// File: rtl/rb_dump_unit.sv
// Register bank debug dumper: reads r0..r(N_REGS-1) through the debug read port and
// streams each word MSB-byte-first to the UART transmitter using a start/done byte handshake.
module rb_dump_unit #(
  parameter int unsigned NB_DATA = 32,
  parameter int unsigned NB_REG  = 5,
  parameter int unsigned N_REGS  = 32,
  parameter int unsigned NB_BYTE = 8
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_start,
  output logic               o_rb_read_enable,
  output logic [NB_REG-1:0]  o_rb_read_address,
  input  logic [NB_DATA-1:0] i_rb_data,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_done,
  output logic               o_busy,
  output logic               o_done
);

  localparam int unsigned N_BYTES = NB_DATA / NB_BYTE;
  localparam int unsigned NB_BIDX = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [NB_BIDX-1:0] LAST_BYTE = NB_BIDX'(N_BYTES - 1);
  localparam logic [NB_REG-1:0]  LAST_REG  = NB_REG'(N_REGS - 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] READ    = 3'd1;
  localparam logic [2:0] WAIT    = 3'd2;
  localparam logic [2:0] LATCH   = 3'd3;
  localparam logic [2:0] SEND    = 3'd4;
  localparam logic [2:0] WAIT_TX = 3'd5;
  localparam logic [2:0] DONE    = 3'd6;

  logic [2:0]         state;
  logic [NB_REG-1:0]  reg_idx;
  logic [NB_BIDX-1:0] byte_idx;
  logic [NB_DATA-1:0] shift;

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state    <= IDLE;
      reg_idx  <= '0;
      byte_idx <= '0;
      shift    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            reg_idx <= '0;
            state   <= READ;
          end
        end
        READ:  state <= WAIT;
        // WAIT absorbs the bank's one-cycle read latency; data is captured in LATCH.
        WAIT:  state <= LATCH;
        LATCH: begin
          shift    <= i_rb_data;
          byte_idx <= '0;
          state    <= SEND;
        end
        SEND:  state <= WAIT_TX;
        WAIT_TX: begin
          if (i_tx_done) begin
            shift    <= shift << NB_BYTE;
            byte_idx <= byte_idx + 1'b1;
            if (byte_idx != LAST_BYTE) begin
              state <= SEND;
            end else if (reg_idx != LAST_REG) begin
              reg_idx <= reg_idx + 1'b1;
              state   <= READ;
            end else begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          reg_idx <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode straight from state; the shift register is zero in IDLE after reset.
  assign o_rb_read_enable  = (state == READ) || (state == WAIT);
  assign o_rb_read_address = o_rb_read_enable ? reg_idx : '0;
  assign o_tx_data         = shift[NB_DATA-1 -: NB_BYTE];
  assign o_tx_start        = (state == SEND);
  assign o_busy            = (state != IDLE);
  assign o_done            = (state == DONE);

endmodule

// File: tb/tb_rb_dump_unit.sv
// Scoreboard bench for rb_dump_unit: register bank and UART TX models, expected byte stream
// derived from the bank contents whenever a dump request is accepted.
module tb_rb_dump_unit;
  localparam int unsigned NB_DATA = 32;
  localparam int unsigned NB_REG  = 5;
  localparam int unsigned N_REGS  = 32;
  localparam int unsigned NB_BYTE = 8;
  localparam int unsigned BPR     = NB_DATA / NB_BYTE;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               rd_en;
  logic [NB_REG-1:0]  rd_addr;
  logic [NB_DATA-1:0] rb_data = '0;
  logic [NB_BYTE-1:0] tx_data;
  logic               tx_start;
  logic               tx_done = 1'b0;
  logic               busy;
  logic               done;

  rb_dump_unit #(.NB_DATA(NB_DATA), .NB_REG(NB_REG), .N_REGS(N_REGS), .NB_BYTE(NB_BYTE)) dut (
    .i_clock(clk), .i_reset(rst_n), .i_start(start),
    .o_rb_read_enable(rd_en), .o_rb_read_address(rd_addr), .i_rb_data(rb_data),
    .o_tx_data(tx_data), .o_tx_start(tx_start), .i_tx_done(tx_done),
    .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [NB_DATA-1:0] bank [N_REGS];
  logic [NB_BYTE-1:0] exp_bytes [$];
  int exp_dones = 0;
  int bytes_seen = 0;
  int tx_delay = 5;
  logic tx_rand = 1'b0;
  logic spur = 1'b0;
  logic tx_wait = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a dump sends every register in address order, most significant byte first.
  task automatic push_dump();
    for (int unsigned r = 0; r < N_REGS; r++)
      for (int unsigned b = 0; b < BPR; b++)
        exp_bytes.push_back(NB_BYTE'(bank[r] >> (NB_DATA - NB_BYTE * (b + 1))));
    exp_dones++;
  endtask

  // Bank: data valid only in the cycle after an enabled address, garbage otherwise.
  always @(posedge clk) rb_data <= rd_en ? bank[rd_addr] : NB_DATA'($urandom);

  // UART TX model, plus optional spurious done pulses whenever no byte is in flight.
  initial begin
    int cnt;
    logic [NB_BYTE-1:0] held;
    cnt = 0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        tx_wait = 1'b0;
        tx_done = 1'b0;
      end else begin
        tx_done = 1'b0;
        if (tx_wait) begin
          chk("tx_start_while_waiting", tx_start, 0);
          cnt--;
          if (cnt == 0) begin
            chk("tx_data_held", tx_data, held);
            tx_done = 1'b1;
            tx_wait = 1'b0;
          end
        end else if (tx_start) begin
          held = tx_data;
          cnt = tx_rand ? int'($urandom_range(1, 6)) : tx_delay;
          tx_wait = 1'b1;
          if (spur) tx_done = 1'b1;
        end else if (spur && $urandom_range(0, 2) == 0) begin
          tx_done = 1'b1;
        end
      end
    end
  end

  // Output monitor: pops the scoreboard on every byte and on every done pulse.
  initial begin
    logic after_done;
    logic [NB_BYTE-1:0] e;
    after_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (tx_start) begin
          bytes_seen++;
          chk("byte_expected", exp_bytes.size() != 0, 1);
          if (exp_bytes.size() != 0) begin
            e = exp_bytes.pop_front();
            chk("tx_byte", tx_data, e);
          end
        end
        if (done) begin
          chk("done_expected", exp_dones > 0, 1);
          chk("bytes_left_at_done", exp_bytes.size(), 0);
          chk("busy_at_done", busy, 1);
          if (exp_dones > 0) exp_dones--;
          after_done = 1'b1;
        end else if (after_done) begin
          chk("busy_after_done", busy, 0);
          after_done = 1'b0;
        end
      end else begin
        after_done = 1'b0;
      end
    end
  end

  // Read-port monitor: each register read holds enable and address for exactly two cycles.
  initial begin
    int run;
    int unsigned exp_addr;
    logic [NB_REG-1:0] run_addr;
    run = 0;
    exp_addr = 0;
    run_addr = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        run = 0;
        exp_addr = 0;
      end else if (rd_en) begin
        if (run == 0) begin
          chk("rd_addr_order", rd_addr, exp_addr);
          run_addr = rd_addr;
        end else begin
          chk("rd_addr_held", rd_addr, run_addr);
        end
        run++;
      end else begin
        chk("rd_addr_idle_zero", rd_addr, 0);
        if (run != 0) begin
          chk("rd_en_cycles", run, 2);
          exp_addr = (exp_addr + 1) % N_REGS;
          run = 0;
        end
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    if (rst_n && !busy) push_dump();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 5000 && busy; i++) @(negedge clk);
    chk("dump_completes", busy, 0);
    repeat (2) @(negedge clk);
    chk("queue_drained", exp_bytes.size(), 0);
    chk("dones_drained", exp_dones, 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rd_en"}, rd_en, 0);
    chk({tag, "_rd_addr"}, rd_addr, 0);
    chk({tag, "_tx_data"}, tx_data, 0);
    chk({tag, "_tx_start"}, tx_start, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  task automatic fill_random();
    for (int unsigned r = 0; r < N_REGS; r++) bank[r] = $urandom;
  endtask

  initial begin
    int base;
    for (int unsigned r = 0; r < N_REGS; r++) bank[r] = '0;

    // Reset held with start asserted
    rst_n = 1'b0;
    start = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_zero("reset");
    end
    start = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_zero("post_reset");

    // Full dump of the patterned bank, TX done five cycles after start
    for (int unsigned r = 0; r < N_REGS; r++) bank[r] = 32'hA0B0C000 + r;
    base = bytes_seen;
    pulse_start();
    wait_idle();
    chk("full_dump_bytes", bytes_seen - base, N_REGS * BPR);

    // Read latency and fastest handshake
    fill_random();
    bank[0] = 32'hDEADBEEF;
    bank[N_REGS-1] = 32'hDEADBEEF;
    tx_delay = 1;
    base = bytes_seen;
    pulse_start();
    wait_idle();
    chk("latency_dump_bytes", bytes_seen - base, N_REGS * BPR);

    // Spurious handshakes and a start re-pulsed mid-dump
    fill_random();
    tx_rand = 1'b1;
    spur = 1'b1;
    repeat (6) @(negedge clk);
    base = bytes_seen;
    pulse_start();
    repeat (200) @(negedge clk);
    pulse_start();
    wait_idle();
    spur = 1'b0;
    chk("spurious_dump_bytes", bytes_seen - base, N_REGS * BPR);

    // Reset while waiting on r5 byte 2, then restart from r0
    tx_rand = 1'b0;
    tx_delay = 5;
    fill_random();
    base = bytes_seen;
    pulse_start();
    for (int i = 0; i < 5000 && !(bytes_seen - base == 5 * BPR + 3 && tx_wait); i++) @(negedge clk);
    chk("reached_r5_byte2", bytes_seen - base, 5 * BPR + 3);
    rst_n = 1'b0;
    @(negedge clk);
    exp_bytes.delete();
    exp_dones = 0;
    check_zero("mid_reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("after_mid_reset");
    fill_random();
    base = bytes_seen;
    pulse_start();
    wait_idle();
    chk("restart_dump_bytes", bytes_seen - base, N_REGS * BPR);

    // Back-to-back dumps, second start in the cycle after o_done
    fill_random();
    tx_rand = 1'b1;
    base = bytes_seen;
    pulse_start();
    for (int i = 0; i < 5000 && !done; i++) @(negedge clk);
    chk("first_done_seen", done, 1);
    pulse_start();
    wait_idle();
    chk("back_to_back_bytes", bytes_seen - base, 2 * N_REGS * BPR);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
